// File: rtl/vc_buf_pkg.sv
// Shared definitions for the multi-VC flit buffer: default geometry,
// derived depth/count widths and a constant clog2 used for parameter checks.
package vc_buf_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_NUM_VC     = 4;
    localparam int DEF_VC_WIDTH   = 2;
    localparam int DEF_AF_MARGIN  = 2;

    // Per-VC depth and an occupancy width that can represent a completely full VC
    localparam int DEPTH          = 2 ** DEF_ADDR_WIDTH;
    localparam int CNT_WIDTH      = DEF_ADDR_WIDTH + 1;

    // Shared RAM is addressed as {vc, ptr}
    localparam int RAM_ADDR_WIDTH = DEF_VC_WIDTH + DEF_ADDR_WIDTH;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/vc_buffer_ram.sv
// Simple dual-port RAM shared by all virtual channels. Small and shallow, so it
// is meant to map onto distributed (LUT) RAM. Synchronous write, registered read
// with a read enable; the read register holds its value when not enabled.
module vc_buffer_ram
    import vc_buf_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int WORDS      = 2 ** RAM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [WORDS];

    // Storage array has no reset; stale words become unreachable once pointers reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register samples the pre-write word, so a same-address collision returns old data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/vc_flit_buffer.sv
// Multi-virtual-channel flit buffer. NUM_VC independent FIFOs share one RAM,
// partitioned by VC index. Each VC keeps its own read/write pointers and an
// occupancy count wide enough to use every slot. Writes to a full VC are dropped
// and reads from an empty VC are ignored, each raising a sticky error flag.
module vc_flit_buffer
    import vc_buf_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_VC     = DEF_NUM_VC,
    parameter int VC_WIDTH   = DEF_VC_WIDTH,
    parameter int AF_MARGIN  = DEF_AF_MARGIN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [VC_WIDTH-1:0]   wr_vc,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [VC_WIDTH-1:0]   rd_vc,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [NUM_VC-1:0]     vc_not_empty,
    output logic [NUM_VC-1:0]     vc_almost_full,
    output logic [NUM_VC-1:0]     vc_full,
    output logic                  overflow_err,
    output logic                  underflow_err,
    input  logic                  err_clr
);

    localparam int VC_DEPTH = 2 ** ADDR_WIDTH;
    localparam int VC_CNT_W = ADDR_WIDTH + 1;
    localparam int RAM_AW   = VC_WIDTH + ADDR_WIDTH;

    localparam logic [VC_CNT_W-1:0] CNT_FULL = VC_CNT_W'(VC_DEPTH);
    localparam logic [VC_CNT_W-1:0] CNT_AF   = VC_CNT_W'(VC_DEPTH - AF_MARGIN);

    // Reject inconsistent geometry at elaboration rather than building a broken buffer
    if (VC_WIDTH != clog2(NUM_VC) || NUM_VC < 2 || AF_MARGIN < 1 || AF_MARGIN >= VC_DEPTH) begin : g_bad_params
        $error("vc_flit_buffer: inconsistent VC_WIDTH/NUM_VC/AF_MARGIN");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr [NUM_VC];
    logic [ADDR_WIDTH-1:0] rd_ptr [NUM_VC];
    logic [VC_CNT_W-1:0]   count  [NUM_VC];

    logic              rd_accept;
    logic              wr_accept;
    logic [NUM_VC-1:0] wr_hit;
    logic [NUM_VC-1:0] rd_hit;

    // Read uses the count before this cycle's write (no bypass); a full VC still takes a write if it is also being read
    always_comb begin
        rd_accept = rd_en && (count[rd_vc] != '0);
        wr_accept = wr_en && ((count[wr_vc] != CNT_FULL) || (rd_accept && (rd_vc == wr_vc)));
        wr_hit    = '0;
        rd_hit    = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            wr_hit[v] = wr_accept && (wr_vc == VC_WIDTH'(v));
            rd_hit[v] = rd_accept && (rd_vc == VC_WIDTH'(v));
        end
    end

    vc_buffer_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (RAM_AW),
        .WORDS      (NUM_VC * VC_DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_accept),
        .waddr ({wr_vc, wr_ptr[wr_vc]}),
        .wdata (wr_data),
        .re    (rd_accept),
        .raddr ({rd_vc, rd_ptr[rd_vc]}),
        .rdata (rd_data)
    );

    // Per-VC pointers and occupancy; simultaneous read and write on one VC leave the count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
                count[v]  <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (wr_hit[v]) begin
                    wr_ptr[v] <= wr_ptr[v] + ADDR_WIDTH'(1);
                end
                if (rd_hit[v]) begin
                    rd_ptr[v] <= rd_ptr[v] + ADDR_WIDTH'(1);
                end
                case ({wr_hit[v], rd_hit[v]})
                    2'b10:   count[v] <= count[v] + VC_CNT_W'(1);
                    2'b01:   count[v] <= count[v] - VC_CNT_W'(1);
                    default: count[v] <= count[v];
                endcase
            end
        end
    end

    // rd_valid marks the cycle after an accepted read and nothing else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_accept;
        end
    end

    // Sticky errors; a new error in the same cycle as err_clr wins so it is never lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (wr_en && !wr_accept) begin
                overflow_err <= 1'b1;
            end else if (err_clr) begin
                overflow_err <= 1'b0;
            end
            if (rd_en && !rd_accept) begin
                underflow_err <= 1'b1;
            end else if (err_clr) begin
                underflow_err <= 1'b0;
            end
        end
    end

    // Status flags decoded from the registered counts
    always_comb begin
        vc_not_empty   = '0;
        vc_almost_full = '0;
        vc_full        = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            vc_not_empty[v]   = (count[v] != '0);
            vc_almost_full[v] = (count[v] >= CNT_AF);
            vc_full[v]        = (count[v] == CNT_FULL);
        end
    end

endmodule
